// File: rtl/sobol_stream_arbiter.sv
// Round-robin, non-preemptive time-sharing of one Sobol dim-1 RNG among NREQ requesters.
// Each grant runs a full 2^RWID-cycle unary stream (val_q > rng_seq) and reports its ones count.
module sobol_stream_arbiter #(
  parameter int RWID = 8,
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*RWID-1:0] value,
  input  logic [RWID-1:0]      rng_seq,
  output logic                 rng_en,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 bit_out,
  output logic                 bit_vld,
  output logic [NREQ-1:0]      done,
  output logic [RWID:0]        cnt_out
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state;
  logic [NREQ-1:0][RWID-1:0]  val_arr;
  logic [RWID-1:0]            val_q;
  logic [RWID-1:0]            phase;
  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              scan_idx;
  logic [PW-1:0]              win_idx;
  logic [PW-1:0]              nxt_ptr;
  logic                       win_vld;
  logic                       smp_bit;
  logic [RWID:0]              acc;
  logic [RWID:0]              acc_nxt;

  assign val_arr = value;

  // Scan from the highest offset down so the closest asserted requester to rr_ptr wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign nxt_ptr = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign smp_bit = (val_q > rng_seq);
  assign acc_nxt = acc + {{RWID{1'b0}}, smp_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      grant   <= '0;
      val_q   <= '0;
      phase   <= '0;
      acc     <= '0;
      rng_en  <= 1'b0;
      busy    <= 1'b0;
      bit_out <= 1'b0;
      bit_vld <= 1'b0;
      done    <= '0;
      cnt_out <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          bit_vld <= 1'b0;
          if (win_vld) begin
            state  <= RUN;
            grant  <= NREQ'(1'b1) << win_idx;
            val_q  <= val_arr[win_idx];
            phase  <= '0;
            acc    <= '0;
            rr_ptr <= nxt_ptr;
            rng_en <= 1'b1;
            busy   <= 1'b1;
          end else begin
            grant <= '0;
          end
        end
        RUN: begin
          bit_out <= smp_bit;
          bit_vld <= 1'b1;
          acc     <= acc_nxt;
          phase   <= phase + 1'b1;
          // Last sample of the period: the RNG wraps back to index 0 on this same edge.
          if (phase == {RWID{1'b1}}) begin
            done    <= grant;
            cnt_out <= acc_nxt;
            grant   <= '0;
            rng_en  <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
